regfile_pc_param: RTL and testbench
===================================

// Module: regfile_pc_param
// PURPOSE
//  Parametrised register file with an internal program-counter register in the top slot.
//  - One synchronous write port and two combinational read ports.
//  - Sits between decode and execute in the processor datapath.
//  - Owns PC sequencing (increment, branch load, write-to-PC), so PC is no longer an external input.
// PARAMETERS
//  N         32   data/register width in bits
//  DEPTH     16   number of architectural registers; power of two, >=4; index DEPTH-1 is PC
//  PC_STEP   4    PC increment per enabled cycle
//  PC_OFFSET 8    value added to PC when PC is read through RD1/RD2
//  RESET_PC  0    PC value after reset
// PORTS
//  clk        in   1             rising-edge clock
//  rst        in   1             asynchronous, active-low reset
//  WE3        in   1             write enable for port 3
//  A1         in   $clog2(DEPTH) read address, port 1
//  A2         in   $clog2(DEPTH) read address, port 2
//  A3         in   $clog2(DEPTH) write address
//  WD3        in   N             write data
//  pc_en      in   1             advance PC by PC_STEP this cycle
//  pc_load    in   1             load PC from pc_target this cycle (branch)
//  pc_target  in   N             branch target
//  RD1        out  N             read data, port 1
//  RD2        out  N             read data, port 2
//  pc_out     out  N             current PC (fetch address)
// BEHAVIOUR
//  - Reset (rst=0, async): r[0..DEPTH-2] <= 0; PC <= RESET_PC.
//    RD1/RD2 therefore show 0, or RESET_PC+PC_OFFSET when addressing PC; pc_out = RESET_PC.
//  - Reset held: all writes, loads and increments are ignored.
//  - Reset release: first update happens at the first rising clk edge with rst=1.
//  - General write: WE3=1 and A3<DEPTH-1 -> r[A3] <= WD3 at the rising edge.
//  - Reads are combinational, zero latency.
//    - A<DEPTH-1 -> r[A].
//    - A==DEPTH-1 -> PC+PC_OFFSET, mod 2^N.
//  - PC update priority, evaluated once per edge:
//    1. WE3=1 and A3==DEPTH-1 -> PC <= WD3 (write-to-PC acts as a branch).
//    2. else pc_load=1 -> PC <= pc_target.
//    3. else pc_en=1 -> PC <= PC+PC_STEP, mod 2^N, silent wrap at 2^N-PC_STEP.
//    4. else PC holds.
//  - Same-cycle write and read of the same register: without bypass, the read returns the old value.
//    The new value is visible from the cycle after the edge.
//  - pc_out = PC register directly. PC_OFFSET is not applied to pc_out.
//  - All arithmetic is unsigned N-bit; carries are dropped.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//   - When WE3=1 and A1==A3 (resp. A2==A3), RD1 (resp. RD2) returns WD3 combinationally.
//   - Applies to general registers only; the PC slot is never bypassed.
//   - Bypass is inactive while rst=0.
//  REGFILE_BYPASS_EN undefined:
//   - No forwarding; same-cycle read-after-write returns the old value.
// TESTING
//  1. Reset with RESET_PC=0.
//     -> all RDx=0 for A<15; RD1 with A1=15 reads 8; pc_out=0.
//  2. WE3=1, A3=3, WD3=32'hDEADBEEF, one edge; then A1=3, A2=3.
//     -> RD1=RD2=32'hDEADBEEF; no other register changes.
//  3. pc_en=1 for 5 edges from 0.
//     -> pc_out=20; A1=15 reads 28.
//     Start at PC=32'hFFFFFFFC, 1 edge -> pc_out=0.
//  4. Same edge: pc_en=1, pc_load=1 with pc_target=32'h100, WE3=1 with A3=15 and WD3=32'h200.
//     -> pc_out=32'h200.
//     Repeat with WE3=0 -> 32'h100.
//  5. WE3=1, A3=5, WD3=7, with A1=5 (r5=1 beforehand).
//     -> RD1=7 before the edge if REGFILE_BYPASS_EN is defined, else 1; after the edge 7 in both builds.
//  6. Assert rst=0 mid-cycle, asynchronously, with PC=32'h40 and r2=9.
//     -> immediately pc_out=RESET_PC and r2 reads 0, without waiting for clk.

Source files
------------

// File: rtl/regfile_pc_param.sv
// Register file whose top slot is an internal PC with increment/branch/write-to-PC sequencing.
// Optional macro REGFILE_BYPASS_EN forwards WD3 to same-cycle reads of general registers.
module regfile_pc_param #(
  parameter int unsigned  N         = 32,
  parameter int unsigned  DEPTH     = 16,
  parameter int unsigned  PC_STEP   = 4,
  parameter int unsigned  PC_OFFSET = 8,
  parameter logic [N-1:0] RESET_PC  = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     WE3,
  input  logic [$clog2(DEPTH)-1:0] A1,
  input  logic [$clog2(DEPTH)-1:0] A2,
  input  logic [$clog2(DEPTH)-1:0] A3,
  input  logic [N-1:0]             WD3,
  input  logic                     pc_en,
  input  logic                     pc_load,
  input  logic [N-1:0]             pc_target,
  output logic [N-1:0]             RD1,
  output logic [N-1:0]             RD2,
  output logic [N-1:0]             pc_out
);

  localparam int unsigned      AW     = $clog2(DEPTH);
  localparam logic [AW-1:0]    PC_IDX = AW'(DEPTH - 1);
  localparam logic [N-1:0]     STEP   = N'(PC_STEP);
  localparam logic [N-1:0]     OFFSET = N'(PC_OFFSET);

  logic [N-1:0] r_regs [DEPTH-1];
  logic [N-1:0] r_pc;

  logic         w_gen_we;
  logic         w_pc_we;
  logic [N-1:0] w_pc_nxt;
  logic [N-1:0] w_pc_rd;
  logic         w_byp1;
  logic         w_byp2;

  assign w_gen_we = WE3 && (A3 != PC_IDX);
  assign w_pc_we  = WE3 && (A3 == PC_IDX);

  // Write-to-PC outranks a branch load, which outranks sequential increment.
  always_comb begin
    w_pc_nxt = r_pc;
    if (w_pc_we) begin
      w_pc_nxt = WD3;
    end else if (pc_load) begin
      w_pc_nxt = pc_target;
    end else if (pc_en) begin
      w_pc_nxt = r_pc + STEP;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc <= RESET_PC;
    end else begin
      r_pc <= w_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_gen_we) begin
      r_regs[A3] <= WD3;
    end
  end

  // PC reads as PC+OFFSET so execute sees the architectural pipeline offset.
  assign w_pc_rd = r_pc + OFFSET;
  assign pc_out  = r_pc;

`ifdef REGFILE_BYPASS_EN
  assign w_byp1 = rst && w_gen_we && (A1 == A3);
  assign w_byp2 = rst && w_gen_we && (A2 == A3);
`else
  assign w_byp1 = 1'b0;
  assign w_byp2 = 1'b0;
`endif

  always_comb begin
    RD1 = '0;
    if (A1 == PC_IDX) begin
      RD1 = w_pc_rd;
    end else if (w_byp1) begin
      RD1 = WD3;
    end else begin
      RD1 = r_regs[A1];
    end
  end

  always_comb begin
    RD2 = '0;
    if (A2 == PC_IDX) begin
      RD2 = w_pc_rd;
    end else if (w_byp2) begin
      RD2 = WD3;
    end else begin
      RD2 = r_regs[A2];
    end
  end

endmodule

// File: tb/tb_regfile_pc_param.sv
// Self-checking bench for regfile_pc_param (default parameters), scoreboard of expected outputs.
module tb_regfile_pc_param;

  logic        clk;
  logic        rst;
  logic        WE3;
  logic [3:0]  A1;
  logic [3:0]  A2;
  logic [3:0]  A3;
  logic [31:0] WD3;
  logic        pc_en;
  logic        pc_load;
  logic [31:0] pc_target;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [31:0] pc_out;

  int n_tests = 0;
  int n_fail  = 0;

  int          q_sel [$];
  logic [31:0] q_exp [$];
  string       q_tag [$];

  logic [31:0] m_regs [15];

  regfile_pc_param dut (
    .clk       (clk),
    .rst       (rst),
    .WE3       (WE3),
    .A1        (A1),
    .A2        (A2),
    .A3        (A3),
    .WD3       (WD3),
    .pc_en     (pc_en),
    .pc_load   (pc_load),
    .pc_target (pc_target),
    .RD1       (RD1),
    .RD2       (RD2),
    .pc_out    (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // sel: 0 = RD1, 1 = RD2, 2 = pc_out
  task automatic push(input int sel, input string tag, input logic [31:0] exp);
    q_sel.push_back(sel);
    q_exp.push_back(exp);
    q_tag.push_back(tag);
  endtask

  task automatic drain();
    int          sel;
    logic [31:0] exp;
    string       tag;
    logic [31:0] got;
    while (q_sel.size() > 0) begin
      sel = q_sel.pop_front();
      exp = q_exp.pop_front();
      tag = q_tag.pop_front();
      got = (sel == 0) ? RD1 : (sel == 1) ? RD2 : pc_out;
      chk(tag, got, exp);
    end
  endtask

  task automatic check_all_regs(input string tag);
    for (int a = 0; a < 15; a++) begin
      @(negedge clk);
      A1 = 4'(a);
      A2 = 4'(14 - a);
      #1;
      push(0, $sformatf("%s_rd1_r%0d", tag, a), m_regs[a]);
      push(1, $sformatf("%s_rd2_r%0d", tag, 14 - a), m_regs[14 - a]);
      drain();
    end
  endtask

  task automatic write_reg(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    WE3 = 1'b1; A3 = a; WD3 = d;
    @(negedge clk);
    WE3 = 1'b0;
    if (a != 4'd15) m_regs[a] = d;
  endtask

  initial begin
    rst = 1'b0; WE3 = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;
    pc_en = 1'b0; pc_load = 1'b0; pc_target = '0;
    for (int i = 0; i < 15; i++) m_regs[i] = '0;

    // Reset state
    @(negedge clk);
    A1 = 4'd15; A2 = 4'd0;
    #1;
    push(0, "rst_pc_read", 32'd8);
    push(1, "rst_r0", 32'd0);
    push(2, "rst_pc_out", 32'd0);
    drain();
    check_all_regs("rst");

    // Held reset ignores writes and increments, and never bypasses
    @(negedge clk);
    WE3 = 1'b1; A3 = 4'd2; WD3 = 32'd5; A1 = 4'd2; pc_en = 1'b1;
    #1;
    push(0, "rst_nobyp", 32'd0);
    drain();
    @(negedge clk);
    push(0, "rst_held_wr", 32'd0);
    push(2, "rst_held_pc", 32'd0);
    drain();
    WE3 = 1'b0;

    // First update occurs at the first edge after release
    rst = 1'b1;
    @(negedge clk);
    pc_en = 1'b0;
    #1;
    push(2, "release_pc", 32'd4);
    push(0, "release_r2", 32'd0);
    drain();
    @(negedge clk);
    pc_load = 1'b1; pc_target = 32'd0;
    @(negedge clk);
    pc_load = 1'b0;

    // Single write, no side effects
    write_reg(4'd3, 32'hDEADBEEF);
    check_all_regs("wr3");
    push(2, "wr3_pc_hold", 32'd0);
    drain();

    // Five increments
    @(negedge clk);
    pc_en = 1'b1;
    repeat (5) @(negedge clk);
    pc_en = 1'b0;
    A1 = 4'd15;
    #1;
    push(2, "inc5_pc", 32'd20);
    push(0, "inc5_pc_read", 32'd28);
    drain();

    // Wrap at the top of the address space
    @(negedge clk);
    pc_load = 1'b1; pc_target = 32'hFFFFFFFC;
    @(negedge clk);
    pc_load = 1'b0;
    #1;
    push(2, "load_top", 32'hFFFFFFFC);
    push(0, "top_read_wrap", 32'd4);
    drain();
    pc_en = 1'b1;
    @(negedge clk);
    pc_en = 1'b0;
    #1;
    push(2, "inc_wrap", 32'd0);
    drain();

    // Priority: write-to-PC > load > increment
    @(negedge clk);
    pc_en = 1'b1; pc_load = 1'b1; pc_target = 32'h100;
    WE3 = 1'b1; A3 = 4'd15; WD3 = 32'h200;
    @(negedge clk);
    WE3 = 1'b0;
    #1;
    push(2, "prio_we", 32'h200);
    drain();
    @(negedge clk);
    pc_en = 1'b0; pc_load = 1'b0;
    #1;
    push(2, "prio_load", 32'h100);
    drain();
    check_all_regs("prio");

    // Same-cycle read-after-write
    write_reg(4'd5, 32'd1);
    WE3 = 1'b1; A3 = 4'd5; WD3 = 32'd7; A1 = 4'd5;
    #1;
`ifdef REGFILE_BYPASS_EN
    push(0, "raw_before", 32'd7);
`else
    push(0, "raw_before", 32'd1);
`endif
    drain();
    @(negedge clk);
    WE3 = 1'b0;
    m_regs[5] = 32'd7;
    #1;
    push(0, "raw_after", 32'd7);
    drain();

    // The PC slot is never forwarded
    @(negedge clk);
    WE3 = 1'b1; A3 = 4'd15; WD3 = 32'h40; A1 = 4'd15;
    #1;
    push(0, "pc_nobyp", 32'h108);
    drain();
    @(negedge clk);
    WE3 = 1'b0;
    #1;
    push(2, "pc_write", 32'h40);
    push(0, "pc_write_read", 32'h48);
    drain();

    // Asynchronous reset mid-cycle
    write_reg(4'd2, 32'd9);
    A1 = 4'd2; A2 = 4'd15;
    #1;
    push(0, "pre_arst_r2", 32'd9);
    push(2, "pre_arst_pc", 32'h40);
    drain();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    push(2, "arst_pc", 32'd0);
    push(0, "arst_r2", 32'd0);
    push(1, "arst_pc_read", 32'd8);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
